// File: rtl/multi_cycle_ctrl_pkg.sv
// Shared constants for the multi-cycle control FSM: opcodes, state codes,
// datapath select encodings and the DECODE dispatch table.
package multi_cycle_ctrl_pkg;

    localparam logic [2:0] OP_RTYPE = 3'b000;
    localparam logic [2:0] OP_ADDI  = 3'b001;
    localparam logic [2:0] OP_LW    = 3'b010;
    localparam logic [2:0] OP_SW    = 3'b011;
    localparam logic [2:0] OP_BEQ   = 3'b100;
    localparam logic [2:0] OP_BNE   = 3'b101;
    localparam logic [2:0] OP_J     = 3'b110;
    localparam logic [2:0] OP_LUI   = 3'b111;

    localparam logic [3:0] FETCH    = 4'd0;
    localparam logic [3:0] DECODE   = 4'd1;
    localparam logic [3:0] EXEC_R   = 4'd2;
    localparam logic [3:0] EXEC_I   = 4'd3;
    localparam logic [3:0] WB_ALU   = 4'd4;
    localparam logic [3:0] MEM_ADDR = 4'd5;
    localparam logic [3:0] MEM_RD   = 4'd6;
    localparam logic [3:0] WB_MEM   = 4'd7;
    localparam logic [3:0] MEM_WR   = 4'd8;
    localparam logic [3:0] BRANCH   = 4'd9;
    localparam logic [3:0] JUMP     = 4'd10;
    localparam logic [3:0] LUI      = 4'd11;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_RT     = 2'd0;
    localparam logic [1:0] SRCB_TWO    = 2'd1;
    localparam logic [1:0] SRCB_IMM    = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH = 2'd3;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    localparam logic [1:0] M2R_ALU = 2'd0;
    localparam logic [1:0] M2R_MDR = 2'd1;
    localparam logic [1:0] M2R_IMM = 2'd2;

    function automatic logic [3:0] decode_dispatch(input logic [2:0] op);
        case (op)
            OP_RTYPE:      return EXEC_R;
            OP_ADDI:       return EXEC_I;
            OP_LW, OP_SW:  return MEM_ADDR;
            OP_BEQ, OP_BNE: return BRANCH;
            OP_J:          return JUMP;
            OP_LUI:        return LUI;
            default:       return FETCH;
        endcase
    endfunction

endpackage

// File: rtl/multi_cycle_ctrl_perf_counter.sv
// Cycle and retired-instruction counters; both clear on reset and wrap.
module perf_counter
    import multi_cycle_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_n,
    input  logic             instr_done_i,
    output logic [CNT_W-1:0] cycle_cnt_o,
    output logic [CNT_W-1:0] instr_cnt_o
);

    logic [CNT_W-1:0] r_cycle_cnt;
    logic [CNT_W-1:0] r_instr_cnt;

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            r_cycle_cnt <= '0;
            r_instr_cnt <= '0;
        end else begin
            r_cycle_cnt <= r_cycle_cnt + 1'b1;
            if (instr_done_i)
                r_instr_cnt <= r_instr_cnt + 1'b1;
        end
    end

    assign cycle_cnt_o = r_cycle_cnt;
    assign instr_cnt_o = r_instr_cnt;

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle CPU control FSM: sequences fetch/decode/execute over a shared memory and ALU.
// Optional counters behind MULTI_CYCLE_CTRL_PERF_EN.
module multi_cycle_ctrl
    import multi_cycle_ctrl_pkg::*;
#(
    parameter int STATE_W = 4
`ifdef MULTI_CYCLE_CTRL_PERF_EN
    , parameter int CNT_W = 16
`endif
) (
    input  logic               clk_i,
    input  logic               rst_n,
    input  logic [2:0]         instr_op_i,
    input  logic               zero_i,
    input  logic               mem_ready_i,
    output logic               pc_write_o,
    output logic [1:0]         pc_src_o,
    output logic               ir_write_o,
    output logic               iord_o,
    output logic               mem_read_o,
    output logic               mem_write_o,
    output logic               alu_src_a_o,
    output logic [1:0]         alu_src_b_o,
    output logic [1:0]         alu_op_o,
    output logic               reg_dst_o,
    output logic [1:0]         mem_to_reg_o,
    output logic               reg_write_o,
    output logic               instr_done_o,
    output logic [STATE_W-1:0] state_o
`ifdef MULTI_CYCLE_CTRL_PERF_EN
    , output logic [CNT_W-1:0] cycle_cnt_o,
    output logic [CNT_W-1:0]   instr_cnt_o
`endif
);

    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_next_state;

    always_ff @(posedge clk_i) begin
        if (!rst_n)
            r_state <= FETCH;
        else
            r_state <= w_next_state;
    end

    // Decode is skipped entirely while in reset so every strobe and select reads 0,
    // which also kills any write the interrupted instruction would have issued.
    always_comb begin
        pc_write_o   = 1'b0;
        pc_src_o     = PCSRC_ALU;
        ir_write_o   = 1'b0;
        iord_o       = 1'b0;
        mem_read_o   = 1'b0;
        mem_write_o  = 1'b0;
        alu_src_a_o  = 1'b0;
        alu_src_b_o  = SRCB_RT;
        alu_op_o     = ALU_ADD;
        reg_dst_o    = 1'b0;
        mem_to_reg_o = M2R_ALU;
        reg_write_o  = 1'b0;
        instr_done_o = 1'b0;
        w_next_state = FETCH;
        if (rst_n) begin
            case (r_state)
                FETCH: begin
                    mem_read_o   = 1'b1;
                    alu_src_b_o  = SRCB_TWO;
                    w_next_state = FETCH;
                    if (mem_ready_i) begin
                        ir_write_o   = 1'b1;
                        pc_write_o   = 1'b1;
                        w_next_state = DECODE;
                    end
                end
                DECODE: begin
                    alu_src_b_o  = SRCB_IMM_SH;
                    w_next_state = decode_dispatch(instr_op_i);
                end
                EXEC_R: begin
                    alu_src_a_o  = 1'b1;
                    alu_op_o     = ALU_FUNCT;
                    w_next_state = WB_ALU;
                end
                EXEC_I: begin
                    alu_src_a_o  = 1'b1;
                    alu_src_b_o  = SRCB_IMM;
                    w_next_state = WB_ALU;
                end
                WB_ALU: begin
                    reg_write_o  = 1'b1;
                    reg_dst_o    = (instr_op_i == OP_RTYPE);
                    instr_done_o = 1'b1;
                end
                MEM_ADDR: begin
                    alu_src_a_o  = 1'b1;
                    alu_src_b_o  = SRCB_IMM;
                    w_next_state = (instr_op_i == OP_SW) ? MEM_WR : MEM_RD;
                end
                MEM_RD: begin
                    iord_o       = 1'b1;
                    mem_read_o   = 1'b1;
                    w_next_state = mem_ready_i ? WB_MEM : MEM_RD;
                end
                WB_MEM: begin
                    reg_write_o  = 1'b1;
                    mem_to_reg_o = M2R_MDR;
                    instr_done_o = 1'b1;
                end
                MEM_WR: begin
                    iord_o       = 1'b1;
                    mem_write_o  = 1'b1;
                    instr_done_o = mem_ready_i;
                    w_next_state = mem_ready_i ? FETCH : MEM_WR;
                end
                BRANCH: begin
                    alu_src_a_o  = 1'b1;
                    alu_op_o     = ALU_SUB;
                    pc_src_o     = PCSRC_ALUOUT;
                    // opcode bit 0 distinguishes bne from beq and inverts the taken sense
                    pc_write_o   = zero_i ^ instr_op_i[0];
                    instr_done_o = 1'b1;
                end
                JUMP: begin
                    pc_src_o     = PCSRC_JUMP;
                    pc_write_o   = 1'b1;
                    instr_done_o = 1'b1;
                end
                LUI: begin
                    reg_write_o  = 1'b1;
                    mem_to_reg_o = M2R_IMM;
                    instr_done_o = 1'b1;
                end
                default: w_next_state = FETCH;
            endcase
        end
    end

    assign state_o = r_state;

`ifdef MULTI_CYCLE_CTRL_PERF_EN
    perf_counter #(
        .CNT_W (CNT_W)
    ) u_perf_counter (
        .clk_i        (clk_i),
        .rst_n        (rst_n),
        .instr_done_i (instr_done_o),
        .cycle_cnt_o  (cycle_cnt_o),
        .instr_cnt_o  (instr_cnt_o)
    );
`endif

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Directed bench for multi_cycle_ctrl: steps one cycle at a time and checks state and control word.
module tb_multi_cycle_ctrl;
    import multi_cycle_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] op = 3'b000;
    logic       zero = 1'b0;
    logic       rdy = 1'b0;

    logic       pc_write, ir_write, iord, mem_read, mem_write, alu_src_a;
    logic       reg_dst, reg_write, instr_done;
    logic [1:0] pc_src, alu_src_b, alu_op, mem_to_reg;
    logic [3:0] state;
`ifdef MULTI_CYCLE_CTRL_PERF_EN
    logic [15:0] cycle_cnt, instr_cnt;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    multi_cycle_ctrl dut (
        .clk_i        (clk),
        .rst_n        (rst_n),
        .instr_op_i   (op),
        .zero_i       (zero),
        .mem_ready_i  (rdy),
        .pc_write_o   (pc_write),
        .pc_src_o     (pc_src),
        .ir_write_o   (ir_write),
        .iord_o       (iord),
        .mem_read_o   (mem_read),
        .mem_write_o  (mem_write),
        .alu_src_a_o  (alu_src_a),
        .alu_src_b_o  (alu_src_b),
        .alu_op_o     (alu_op),
        .reg_dst_o    (reg_dst),
        .mem_to_reg_o (mem_to_reg),
        .reg_write_o  (reg_write),
        .instr_done_o (instr_done),
        .state_o      (state)
`ifdef MULTI_CYCLE_CTRL_PERF_EN
        , .cycle_cnt_o (cycle_cnt),
        .instr_cnt_o  (instr_cnt)
`endif
    );

    logic [16:0] obs_cw;
    assign obs_cw = {pc_write, pc_src, ir_write, iord, mem_read, mem_write,
                     alu_src_a, alu_src_b, alu_op, reg_dst, mem_to_reg, reg_write, instr_done};

    function automatic logic [16:0] cw(input logic pcw, input logic [1:0] pcs, input logic irw,
                                       input logic io, input logic mr, input logic mw,
                                       input logic asa, input logic [1:0] asb, input logic [1:0] aop,
                                       input logic rd, input logic [1:0] m2r, input logic rw,
                                       input logic dn);
        return {pcw, pcs, irw, io, mr, mw, asa, asb, aop, rd, m2r, rw, dn};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Drive inputs on the falling edge, then check the settled Moore/FETCH outputs.
    task automatic cyc(input string tag, input logic r, input logic [2:0] o, input logic z,
                       input logic m, input logic [3:0] es, input logic [16:0] ew);
        @(negedge clk);
        rst_n = r;
        op    = o;
        zero  = z;
        rdy   = m;
        #2;
        check({tag, ".state"}, {28'd0, state}, {28'd0, es});
        check({tag, ".ctl"}, {15'd0, obs_cw}, {15'd0, ew});
    endtask

    logic [16:0] W_IDLE, W_F_RDY, W_F_WAIT, W_DEC, W_EXR, W_EXI, W_WB_R, W_WB_I;
    logic [16:0] W_MADDR, W_MRD, W_WBM, W_BR_T, W_BR_N, W_MWR_RDY, W_MWR_WAIT, W_JMP, W_LUI;

    initial begin
        //             pcw pcs irw io mr mw asa asb aop rd m2r rw dn
        W_IDLE     = cw(0, 0,  0,  0, 0, 0, 0,  0,  0,  0, 0,  0, 0);
        W_F_RDY    = cw(1, 0,  1,  0, 1, 0, 0,  1,  0,  0, 0,  0, 0);
        W_F_WAIT   = cw(0, 0,  0,  0, 1, 0, 0,  1,  0,  0, 0,  0, 0);
        W_DEC      = cw(0, 0,  0,  0, 0, 0, 0,  3,  0,  0, 0,  0, 0);
        W_EXR      = cw(0, 0,  0,  0, 0, 0, 1,  0,  2,  0, 0,  0, 0);
        W_EXI      = cw(0, 0,  0,  0, 0, 0, 1,  2,  0,  0, 0,  0, 0);
        W_WB_R     = cw(0, 0,  0,  0, 0, 0, 0,  0,  0,  1, 0,  1, 1);
        W_WB_I     = cw(0, 0,  0,  0, 0, 0, 0,  0,  0,  0, 0,  1, 1);
        W_MADDR    = cw(0, 0,  0,  0, 0, 0, 1,  2,  0,  0, 0,  0, 0);
        W_MRD      = cw(0, 0,  0,  1, 1, 0, 0,  0,  0,  0, 0,  0, 0);
        W_WBM      = cw(0, 0,  0,  0, 0, 0, 0,  0,  0,  0, 1,  1, 1);
        W_BR_T     = cw(1, 1,  0,  0, 0, 0, 1,  0,  1,  0, 0,  0, 1);
        W_BR_N     = cw(0, 1,  0,  0, 0, 0, 1,  0,  1,  0, 0,  0, 1);
        W_MWR_RDY  = cw(0, 0,  0,  1, 0, 1, 0,  0,  0,  0, 0,  0, 1);
        W_MWR_WAIT = cw(0, 0,  0,  1, 0, 1, 0,  0,  0,  0, 0,  0, 0);
        W_JMP      = cw(1, 2,  0,  0, 0, 0, 0,  0,  0,  0, 0,  0, 1);
        W_LUI      = cw(0, 0,  0,  0, 0, 0, 0,  0,  0,  0, 2,  1, 1);

        // reset: outputs forced to 0 even with memory ready
        cyc("rst0", 0, OP_RTYPE, 0, 0, FETCH, W_IDLE);
        cyc("rst1", 0, OP_RTYPE, 0, 1, FETCH, W_IDLE);

        // R-type, zero-wait: 4 cycles
        cyc("r.f",  1, OP_RTYPE, 0, 1, FETCH,  W_F_RDY);
        cyc("r.d",  1, OP_RTYPE, 0, 1, DECODE, W_DEC);
        cyc("r.x",  1, OP_RTYPE, 0, 1, EXEC_R, W_EXR);
        cyc("r.wb", 1, OP_RTYPE, 0, 1, WB_ALU, W_WB_R);

        // lw with one fetch wait and two read waits
        cyc("lw.fw", 1, OP_LW, 0, 0, FETCH,    W_F_WAIT);
        cyc("lw.f",  1, OP_LW, 0, 1, FETCH,    W_F_RDY);
        cyc("lw.d",  1, OP_LW, 0, 0, DECODE,   W_DEC);
        cyc("lw.a",  1, OP_LW, 0, 0, MEM_ADDR, W_MADDR);
        cyc("lw.r1", 1, OP_LW, 0, 0, MEM_RD,   W_MRD);
        cyc("lw.r2", 1, OP_LW, 0, 0, MEM_RD,   W_MRD);
        cyc("lw.r3", 1, OP_LW, 0, 1, MEM_RD,   W_MRD);
        cyc("lw.wb", 1, OP_LW, 0, 1, WB_MEM,   W_WBM);

        // addi writes back to IR[9:7]
        cyc("ai.f",  1, OP_ADDI, 0, 1, FETCH,  W_F_RDY);
        cyc("ai.d",  1, OP_ADDI, 0, 1, DECODE, W_DEC);
        cyc("ai.x",  1, OP_ADDI, 0, 1, EXEC_I, W_EXI);
        cyc("ai.wb", 1, OP_ADDI, 0, 1, WB_ALU, W_WB_I);

        // branches: beq z=1 taken, bne z=1 not, bne z=0 taken
        cyc("beq.f", 1, OP_BEQ, 1, 1, FETCH,  W_F_RDY);
        cyc("beq.d", 1, OP_BEQ, 1, 1, DECODE, W_DEC);
        cyc("beq.b", 1, OP_BEQ, 1, 1, BRANCH, W_BR_T);
        cyc("bne.f", 1, OP_BNE, 1, 1, FETCH,  W_F_RDY);
        cyc("bne.d", 1, OP_BNE, 1, 1, DECODE, W_DEC);
        cyc("bne.b", 1, OP_BNE, 1, 1, BRANCH, W_BR_N);
        cyc("bn0.f", 1, OP_BNE, 0, 1, FETCH,  W_F_RDY);
        cyc("bn0.d", 1, OP_BNE, 0, 1, DECODE, W_DEC);
        cyc("bn0.b", 1, OP_BNE, 0, 1, BRANCH, W_BR_T);

        // sw zero-wait, then sw with one write wait
        cyc("sw.f",  1, OP_SW, 0, 1, FETCH,    W_F_RDY);
        cyc("sw.d",  1, OP_SW, 0, 1, DECODE,   W_DEC);
        cyc("sw.a",  1, OP_SW, 0, 1, MEM_ADDR, W_MADDR);
        cyc("sw.w",  1, OP_SW, 0, 1, MEM_WR,   W_MWR_RDY);
        cyc("sw2.f", 1, OP_SW, 0, 1, FETCH,    W_F_RDY);
        cyc("sw2.d", 1, OP_SW, 0, 1, DECODE,   W_DEC);
        cyc("sw2.a", 1, OP_SW, 0, 1, MEM_ADDR, W_MADDR);
        cyc("sw2.h", 1, OP_SW, 0, 0, MEM_WR,   W_MWR_WAIT);
        cyc("sw2.w", 1, OP_SW, 0, 1, MEM_WR,   W_MWR_RDY);

        // jump and lui: 3 cycles each
        cyc("j.f",   1, OP_J,   0, 1, FETCH,  W_F_RDY);
        cyc("j.d",   1, OP_J,   0, 1, DECODE, W_DEC);
        cyc("j.j",   1, OP_J,   0, 1, JUMP,   W_JMP);
        cyc("lui.f", 1, OP_LUI, 0, 1, FETCH,  W_F_RDY);
        cyc("lui.d", 1, OP_LUI, 0, 1, DECODE, W_DEC);
        cyc("lui.l", 1, OP_LUI, 0, 1, LUI,    W_LUI);

        // reset asserted while in MEM_WR aborts the store
        cyc("ab.f",  1, OP_SW, 0, 1, FETCH,    W_F_RDY);
        cyc("ab.d",  1, OP_SW, 0, 1, DECODE,   W_DEC);
        cyc("ab.a",  1, OP_SW, 0, 1, MEM_ADDR, W_MADDR);
        cyc("ab.w",  0, OP_SW, 0, 1, MEM_WR,   W_IDLE);
        cyc("ab.r",  0, OP_SW, 0, 1, FETCH,    W_IDLE);
`ifdef MULTI_CYCLE_CTRL_PERF_EN
        check("cycle_cnt.rst", {16'd0, cycle_cnt}, 32'd0);
        check("instr_cnt.rst", {16'd0, instr_cnt}, 32'd0);
`endif
        cyc("ab.f2", 1, OP_RTYPE, 0, 1, FETCH,  W_F_RDY);
        cyc("ab.d2", 1, OP_RTYPE, 0, 1, DECODE, W_DEC);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
